bp_me_mem_arbiter: RTL
======================

Name: bp_me_mem_arbiter

Overview:
- Shares one memory-end port (one bp_mem instance) among num_cce_p CCE memory channels.
- Round-robin arbitrates the CCE mem_cmd and mem_data_cmd channels independently onto the single memory command channels.
- Records each grant in in-order route FIFOs and steers memory responses back to the originating CCE.
- Sits between bp_me_top's per-CCE memory ports and a single bp_mem.

Parameters:
- num_cce_p, 2, number of requesting CCEs (>=1).
- mem_cmd_width_p, 64, packed bp_cce_mem_cmd_s width.
- mem_data_cmd_width_p, 576, packed bp_cce_mem_data_cmd_s width.
- mem_resp_width_p, 64, packed bp_mem_cce_resp_s width.
- mem_data_resp_width_p, 576, packed bp_mem_cce_data_resp_s width.
- route_els_p, 4, depth of each route FIFO (max outstanding per channel pair).
- Derived localparam cce_id_width_lp = `BSG_SAFE_CLOG2(num_cce_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- cce_mem_cmd_i  in  num_cce_p x mem_cmd_width_p  per-CCE commands.
- cce_mem_cmd_v_i  in  num_cce_p  valid.
- cce_mem_cmd_yumi_o  out  num_cce_p  consume.
- cce_mem_data_cmd_i  in  num_cce_p x mem_data_cmd_width_p  per-CCE writeback commands.
- cce_mem_data_cmd_v_i  in  num_cce_p  valid.
- cce_mem_data_cmd_yumi_o  out  num_cce_p  consume.
- cce_mem_resp_o  out  num_cce_p x mem_resp_width_p  routed write acks.
- cce_mem_resp_v_o  out  num_cce_p  valid.
- cce_mem_resp_ready_i  in  num_cce_p  ready.
- cce_mem_data_resp_o  out  num_cce_p x mem_data_resp_width_p  routed read data.
- cce_mem_data_resp_v_o  out  num_cce_p  valid.
- cce_mem_data_resp_ready_i  in  num_cce_p  ready.
- mem_cmd_o  out  mem_cmd_width_p  to memory.
- mem_cmd_v_o  out  1  valid.
- mem_cmd_yumi_i  in  1  memory consume.
- mem_data_cmd_o  out  mem_data_cmd_width_p  to memory.
- mem_data_cmd_v_o  out  1  valid.
- mem_data_cmd_yumi_i  in  1  memory consume.
- mem_resp_i  in  mem_resp_width_p  from memory.
- mem_resp_v_i  in  1  valid.
- mem_resp_ready_o  out  1  ready.
- mem_data_resp_i  in  mem_data_resp_width_p  from memory.
- mem_data_resp_v_i  in  1  valid.
- mem_data_resp_ready_o  out  1  ready.

Behaviour:
- One clock domain; reset_i is synchronous and active-high.
- Reset state:
  - Both RR pointers = 0.
  - Both route FIFOs empty.
  - All valid and yumi outputs = 0; mem_resp_ready_o = mem_data_resp_ready_o = 0.
  - Payload outputs are don't-care.
- Cmd arbiter:
  - grant = first i with cce_mem_cmd_v_i[i], scanning from rr_cmd_ptr upward with wrap.
  - mem_cmd_v_o = |cce_mem_cmd_v_i & ~read_fifo_full.
  - mem_cmd_o = cce_mem_cmd_i[grant], combinational, zero latency.
  - On mem_cmd_yumi_i:
    - cce_mem_cmd_yumi_o[grant] = 1 in the same cycle; no other yumi bits set.
    - grant is pushed to read_fifo.
    - rr_cmd_ptr <= grant+1, wrapping to 0 at num_cce_p.
  - RR pointer changes only on yumi, so grant is stable while upstream holds valid.
  - Upstream valid/yumi sources never drop valid before yumi.
- Data-cmd arbiter: identical and independent, using rr_data_ptr and write_fifo. It routes mem_data_cmd.
- Response steering:
  - Memory responds in order per channel: data_resp answers mem_cmd; resp answers mem_data_cmd.
  - head = read_fifo head.
  - cce_mem_data_resp_v_o[head] = mem_data_resp_v_i & ~read_fifo_empty; all other bits 0.
  - mem_data_resp_ready_o = ~read_fifo_empty & cce_mem_data_resp_ready_i[head].
  - Pop on mem_data_resp_v_i & mem_data_resp_ready_o.
  - The payload is broadcast to all cce_mem_data_resp_o entries.
  - mem_resp / write_fifo are symmetric.
- Full FIFO:
  - v_o is masked by the registered full flag only.
  - A same-cycle pop does not enable a push; the push is accepted the next cycle.
- Empty FIFO: ready_o = 0 and the response is held by memory. A response valid with an empty FIFO is a protocol error; a nonsynth assertion fires.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
- num_cce_p = 1: grant is always 0; the FIFOs still bound outstanding requests.
- Reset mid-operation:
  - FIFOs and pointers are cleared the next cycle.
  - In-flight responses are dropped; system reset covers memory as well.

Test Plan:
- Single requester: CCE1 cmd valid, memory yumi on cycle 3 → mem_cmd_v_o=1 from cycle 0 with CCE1 payload; yumi_o=2'b10 on cycle 3 only. Data_resp then routes to CCE1, v_o=2'b10.
- Contention: both CCEs hold cmd valid, memory yumis every cycle → grant order 0,1,0,1; rr_cmd_ptr alternates. Four data_resps route 0,1,0,1.
- Back-pressure: route_els_p=4, memory yumis 4 cmds with no responses → mem_cmd_v_o=0 on the 5th. One response pops the FIFO; v_o returns the following cycle.
- Blocked head: read_fifo head=CCE0 with cce_mem_data_resp_ready_i=2'b10 → mem_data_resp_ready_o=0 until ready[0]=1. CCE1 never sees valid.
- Independent channels: CCE0 data_cmd and CCE1 cmd in the same cycle, both yumied → the two issue concurrently. Resp routes to CCE0 and data_resp to CCE1, in either arrival order.
- Reset with 3 outstanding → the cycle after reset, all v_o=0, ready_o=0, and pointers are 0.

Source files
------------

// File: rtl/bp_me_mem_arbiter.sv
// Shares one memory port among several CCE memory channels: round-robin command
// arbitration per channel, with in-order route FIFOs steering responses back.
module bp_me_mem_arbiter #(
    parameter int num_cce_p             = 2,
    parameter int mem_cmd_width_p       = 64,
    parameter int mem_data_cmd_width_p  = 576,
    parameter int mem_resp_width_p      = 64,
    parameter int mem_data_resp_width_p = 576,
    parameter int route_els_p           = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,

    input  logic [num_cce_p*mem_cmd_width_p-1:0]       cce_mem_cmd_i,
    input  logic [num_cce_p-1:0]                       cce_mem_cmd_v_i,
    output logic [num_cce_p-1:0]                       cce_mem_cmd_yumi_o,

    input  logic [num_cce_p*mem_data_cmd_width_p-1:0]  cce_mem_data_cmd_i,
    input  logic [num_cce_p-1:0]                       cce_mem_data_cmd_v_i,
    output logic [num_cce_p-1:0]                       cce_mem_data_cmd_yumi_o,

    output logic [num_cce_p*mem_resp_width_p-1:0]      cce_mem_resp_o,
    output logic [num_cce_p-1:0]                       cce_mem_resp_v_o,
    input  logic [num_cce_p-1:0]                       cce_mem_resp_ready_i,

    output logic [num_cce_p*mem_data_resp_width_p-1:0] cce_mem_data_resp_o,
    output logic [num_cce_p-1:0]                       cce_mem_data_resp_v_o,
    input  logic [num_cce_p-1:0]                       cce_mem_data_resp_ready_i,

    output logic [mem_cmd_width_p-1:0]                 mem_cmd_o,
    output logic                                       mem_cmd_v_o,
    input  logic                                       mem_cmd_yumi_i,

    output logic [mem_data_cmd_width_p-1:0]            mem_data_cmd_o,
    output logic                                       mem_data_cmd_v_o,
    input  logic                                       mem_data_cmd_yumi_i,

    input  logic [mem_resp_width_p-1:0]                mem_resp_i,
    input  logic                                       mem_resp_v_i,
    output logic                                       mem_resp_ready_o,

    input  logic [mem_data_resp_width_p-1:0]           mem_data_resp_i,
    input  logic                                       mem_data_resp_v_i,
    output logic                                       mem_data_resp_ready_o
);

    localparam int cce_id_width_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;
    localparam int ptr_width_lp    = (route_els_p > 1) ? $clog2(route_els_p) : 1;
    localparam int cnt_width_lp    = $clog2(route_els_p + 1);

    typedef logic [cce_id_width_lp-1:0] cce_id_t;
    typedef logic [ptr_width_lp-1:0]    fifo_ptr_t;
    typedef logic [cnt_width_lp-1:0]    fifo_cnt_t;

    // First valid requester at or above ptr, wrapping past the last CCE.
    function automatic cce_id_t rr_pick(input logic [num_cce_p-1:0] v, input cce_id_t ptr);
        cce_id_t                  pick;
        logic                     found;
        logic [cce_id_width_lp:0] sum;
        cce_id_t                  id;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < num_cce_p; k++) begin
            sum = {1'b0, ptr} + (cce_id_width_lp+1)'(k);
            if (sum >= (cce_id_width_lp+1)'(num_cce_p)) begin
                sum = sum - (cce_id_width_lp+1)'(num_cce_p);
            end
            id = sum[cce_id_width_lp-1:0];
            if (!found && v[id]) begin
                pick  = id;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic cce_id_t next_id(input cce_id_t id);
        return (id == cce_id_t'(num_cce_p - 1)) ? '0 : id + cce_id_t'(1);
    endfunction

    function automatic fifo_ptr_t next_ptr(input fifo_ptr_t p);
        return (p == fifo_ptr_t'(route_els_p - 1)) ? '0 : p + fifo_ptr_t'(1);
    endfunction

    cce_id_t   rr_cmd_ptr_q,  rr_cmd_ptr_d;
    cce_id_t   rr_data_ptr_q, rr_data_ptr_d;

    cce_id_t   read_mem_q  [route_els_p];
    fifo_ptr_t read_rptr_q,  read_rptr_d,  read_wptr_q,  read_wptr_d;
    fifo_cnt_t read_cnt_q,   read_cnt_d;
    cce_id_t   write_mem_q [route_els_p];
    fifo_ptr_t write_rptr_q, write_rptr_d, write_wptr_q, write_wptr_d;
    fifo_cnt_t write_cnt_q,  write_cnt_d;

    cce_id_t   cmd_grant, data_grant, read_head, write_head;
    logic      read_full, read_empty, write_full, write_empty;
    logic      cmd_fire, data_fire, read_pop, write_pop;

    assign read_full   = (read_cnt_q == fifo_cnt_t'(route_els_p));
    assign read_empty  = (read_cnt_q == '0);
    assign write_full  = (write_cnt_q == fifo_cnt_t'(route_els_p));
    assign write_empty = (write_cnt_q == '0);
    assign read_head   = read_mem_q[read_rptr_q];
    assign write_head  = write_mem_q[write_rptr_q];

    assign cmd_grant  = rr_pick(cce_mem_cmd_v_i, rr_cmd_ptr_q);
    assign data_grant = rr_pick(cce_mem_data_cmd_v_i, rr_data_ptr_q);

    // Outputs are held quiet while reset is asserted, whatever upstream presents.
    assign mem_cmd_v_o      = ~reset_i & (|cce_mem_cmd_v_i) & ~read_full;
    assign mem_data_cmd_v_o = ~reset_i & (|cce_mem_data_cmd_v_i) & ~write_full;
    assign cmd_fire         = mem_cmd_v_o & mem_cmd_yumi_i;
    assign data_fire        = mem_data_cmd_v_o & mem_data_cmd_yumi_i;

    assign cce_mem_cmd_yumi_o      = cmd_fire  ? (num_cce_p'(1) << cmd_grant)  : '0;
    assign cce_mem_data_cmd_yumi_o = data_fire ? (num_cce_p'(1) << data_grant) : '0;

    always_comb begin
        mem_cmd_o      = '0;
        mem_data_cmd_o = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            if (cmd_grant == cce_id_t'(i)) begin
                mem_cmd_o = cce_mem_cmd_i[i*mem_cmd_width_p +: mem_cmd_width_p];
            end
            if (data_grant == cce_id_t'(i)) begin
                mem_data_cmd_o = cce_mem_data_cmd_i[i*mem_data_cmd_width_p +: mem_data_cmd_width_p];
            end
        end
    end

    assign mem_data_resp_ready_o = ~reset_i & ~read_empty & cce_mem_data_resp_ready_i[read_head];
    assign mem_resp_ready_o      = ~reset_i & ~write_empty & cce_mem_resp_ready_i[write_head];
    assign read_pop              = mem_data_resp_v_i & mem_data_resp_ready_o;
    assign write_pop             = mem_resp_v_i & mem_resp_ready_o;

    assign cce_mem_data_resp_v_o = (~reset_i & mem_data_resp_v_i & ~read_empty)
                                   ? (num_cce_p'(1) << read_head) : '0;
    assign cce_mem_resp_v_o      = (~reset_i & mem_resp_v_i & ~write_empty)
                                   ? (num_cce_p'(1) << write_head) : '0;
    assign cce_mem_data_resp_o   = {num_cce_p{mem_data_resp_i}};
    assign cce_mem_resp_o        = {num_cce_p{mem_resp_i}};

    always_comb begin
        rr_cmd_ptr_d  = cmd_fire  ? next_id(cmd_grant)  : rr_cmd_ptr_q;
        rr_data_ptr_d = data_fire ? next_id(data_grant) : rr_data_ptr_q;

        read_wptr_d  = cmd_fire  ? next_ptr(read_wptr_q)  : read_wptr_q;
        read_rptr_d  = read_pop  ? next_ptr(read_rptr_q)  : read_rptr_q;
        write_wptr_d = data_fire ? next_ptr(write_wptr_q) : write_wptr_q;
        write_rptr_d = write_pop ? next_ptr(write_rptr_q) : write_rptr_q;

        read_cnt_d = read_cnt_q;
        case ({cmd_fire, read_pop})
            2'b10:   read_cnt_d = read_cnt_q + fifo_cnt_t'(1);
            2'b01:   read_cnt_d = read_cnt_q - fifo_cnt_t'(1);
            default: read_cnt_d = read_cnt_q;
        endcase

        write_cnt_d = write_cnt_q;
        case ({data_fire, write_pop})
            2'b10:   write_cnt_d = write_cnt_q + fifo_cnt_t'(1);
            2'b01:   write_cnt_d = write_cnt_q - fifo_cnt_t'(1);
            default: write_cnt_d = write_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_cmd_ptr_q  <= '0;
            rr_data_ptr_q <= '0;
            read_rptr_q   <= '0;
            read_wptr_q   <= '0;
            read_cnt_q    <= '0;
            write_rptr_q  <= '0;
            write_wptr_q  <= '0;
            write_cnt_q   <= '0;
        end else begin
            rr_cmd_ptr_q  <= rr_cmd_ptr_d;
            rr_data_ptr_q <= rr_data_ptr_d;
            read_rptr_q   <= read_rptr_d;
            read_wptr_q   <= read_wptr_d;
            read_cnt_q    <= read_cnt_d;
            write_rptr_q  <= write_rptr_d;
            write_wptr_q  <= write_wptr_d;
            write_cnt_q   <= write_cnt_d;
        end
    end

    // Route storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk_i) begin
        if (cmd_fire) begin
            read_mem_q[read_wptr_q] <= cmd_grant;
        end
        if (data_fire) begin
            write_mem_q[write_wptr_q] <= data_grant;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_data_resp_v_i && read_empty))
                else $error("bp_me_mem_arbiter: data response with no outstanding read");
            assert (!(mem_resp_v_i && write_empty))
                else $error("bp_me_mem_arbiter: write ack with no outstanding writeback");
        end
    end
`endif

endmodule
